// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU execution sequencer: state encoding, status
// codes, opcode limits and instruction field positions.
package alu_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_READ_A = 4'd2,
    ST_READ_B = 4'd3,
    ST_EXEC   = 4'd4,
    ST_WAIT   = 4'd5,
    ST_WRITE  = 4'd6,
    ST_DONE   = 4'd7,
    ST_FAULT  = 4'd8
  } state_t;

  localparam logic [1:0] STATUS_IDLE  = 2'b00;
  localparam logic [1:0] STATUS_BUSY  = 2'b01;
  localparam logic [1:0] STATUS_DONE  = 2'b10;
  localparam logic [1:0] STATUS_FAULT = 2'b11;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_MAX_VALID = 4'hC;

  localparam int FIELD_W  = 4;
  localparam int OPC_LSB  = 8;
  localparam int SRCA_LSB = 4;
  localparam int SRCB_LSB = 0;

  function automatic logic [1:0] state_status(input state_t st);
    logic [1:0] code;
    case (st)
      ST_IDLE:  code = STATUS_IDLE;
      ST_DONE:  code = STATUS_DONE;
      ST_FAULT: code = STATUS_FAULT;
      default:  code = STATUS_BUSY;
    endcase
    return code;
  endfunction

  function automatic logic op_invalid(input logic [3:0] op);
    return (op > OP_MAX_VALID);
  endfunction

endpackage

// File: rtl/alu_seq_watchdog.sv
// Cycle counter guarding the ALU wait; flags the cycle whose increment would
// bring the count to TIMEOUT.
module alu_seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_r;

  // Wait-cycle counter, saturating at TIMEOUT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && (cnt_r != CW'(TIMEOUT))) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign expired = enable && (cnt_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_sequencer.sv
// Execution controller: drains the instruction FIFO, fetches two operands per
// instruction, runs the ALU core and pushes results, reporting a 2-bit status.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic              opdone_clear,
  output logic [1:0]        status,
  input  logic              inst_empty,
  input  logic [31:0]       inst_dout,
  output logic              inst_pop,
  output logic [RF_AW-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              res_full,
  output logic              res_push,
  output logic [DATA_W-1:0] res_din
);

  state_t              state_r;
  state_t              state_s;
  logic [1:0]          status_r;
  logic [3:0]          op_r;
  logic [3:0]          srcb_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   result_r;
  logic [RF_AW-1:0]    rf_raddr_r;
  logic [3:0]          alu_op_r;
  logic [DATA_W-1:0]   alu_a_r;
  logic [DATA_W-1:0]   alu_b_r;
  logic                alu_start_r;
  logic                wd_clear_s;
  logic                wd_en_s;
  logic                wd_expired_s;
  logic                unused_inst_hi_s;

  assign unused_inst_hi_s = ^inst_dout[31:12];

  alu_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear_s),
    .enable  (wd_en_s),
    .expired (wd_expired_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and watchdog control
  always_comb begin
    state_s    = state_r;
    wd_clear_s = 1'b0;
    wd_en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (op_start) state_s = ST_FETCH;
        else          state_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (inst_empty) state_s = ST_DONE;
        else            state_s = ST_READ_A;
      end
      ST_READ_A: begin
        if (op_invalid(op_r))     state_s = ST_FAULT;
        else if (op_r == OP_NOP)  state_s = ST_FETCH;
        else                      state_s = ST_READ_B;
      end
      ST_READ_B: state_s = ST_EXEC;
      ST_EXEC: begin
        wd_clear_s = 1'b1;
        state_s    = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_done) begin
          state_s = ST_WRITE;
        end else begin
          wd_en_s = 1'b1;
          if (wd_expired_s) state_s = ST_FAULT;
          else              state_s = ST_WAIT;
        end
      end
      ST_WRITE: begin
        if (res_full) state_s = ST_FAULT;
        else          state_s = ST_FETCH;
      end
      ST_DONE, ST_FAULT: begin
        if (opdone_clear) state_s = ST_IDLE;
        else              state_s = state_r;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath registers; operands are presented to the ALU from EXEC onward
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_r    <= STATUS_IDLE;
      alu_start_r <= 1'b0;
      op_r        <= 4'h0;
      srcb_r      <= 4'h0;
      a_r         <= {DATA_W{1'b0}};
      result_r    <= {DATA_W{1'b0}};
      rf_raddr_r  <= {RF_AW{1'b0}};
      alu_op_r    <= 4'h0;
      alu_a_r     <= {DATA_W{1'b0}};
      alu_b_r     <= {DATA_W{1'b0}};
    end else begin
      status_r    <= state_status(state_s);
      alu_start_r <= (state_s == ST_EXEC);
      case (state_r)
        ST_FETCH: begin
          if (!inst_empty) begin
            op_r       <= inst_dout[OPC_LSB +: FIELD_W];
            srcb_r     <= inst_dout[SRCB_LSB +: FIELD_W];
            rf_raddr_r <= RF_AW'(inst_dout[SRCA_LSB +: FIELD_W]);
          end
        end
        ST_READ_A: begin
          a_r        <= rf_rdata;
          rf_raddr_r <= RF_AW'(srcb_r);
        end
        ST_READ_B: begin
          alu_op_r <= op_r;
          alu_a_r  <= a_r;
          alu_b_r  <= rf_rdata;
        end
        ST_WAIT: begin
          if (alu_done) result_r <= alu_result;
        end
        default: begin
        end
      endcase
    end
  end

  assign status    = status_r;
  assign alu_start = alu_start_r;
  assign rf_raddr  = rf_raddr_r;
  assign alu_op    = alu_op_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign res_din   = result_r;
  assign inst_pop  = (state_r == ST_FETCH) && !inst_empty;
  assign res_push  = (state_r == ST_WRITE) && !res_full;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: FIFO, register file, ALU core and
// result FIFO are modelled here; expectations come from a program-level model.
module tb_alu_sequencer;

  localparam int DATA_W  = 32;
  localparam int RF_AW   = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              op_start = 1'b0;
  logic              opdone_clear = 1'b0;
  logic              res_full = 1'b0;
  logic [1:0]        status;
  logic              inst_empty;
  logic [31:0]       inst_dout;
  logic              inst_pop;
  logic [RF_AW-1:0]  rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_start;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result = 32'd0;
  logic              res_push;
  logic [DATA_W-1:0] res_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(DATA_W), .RF_AW(RF_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .opdone_clear(opdone_clear),
    .status(status), .inst_empty(inst_empty), .inst_dout(inst_dout), .inst_pop(inst_pop),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .res_full(res_full), .res_push(res_push), .res_din(res_din)
  );

  // Environment: instruction FIFO (fall-through head), register file, cycle count
  logic [31:0] fifo_mem [0:1023];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int cyc = 0;
  logic [31:0] rf [0:15];
  assign inst_dout  = fifo_mem[rd_ptr[9:0]];
  assign inst_empty = (rd_ptr == wr_ptr);
  assign rf_rdata   = rf[rf_raddr];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (inst_pop) rd_ptr <= rd_ptr + 1;

  // Stand-in ALU core behaviour
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd1: r = a + b;
      4'd2: r = a - b;
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = a << b[4:0];
      4'd7: r = a >> b[4:0];
      4'd8: r = (a < b) ? 32'd1 : 32'd0;
      default: r = a + {28'd0, op};
    endcase
    return r;
  endfunction

  int alu_lat = 1;
  bit alu_hang = 1'b0;
  int pend = 0;
  logic done_r = 1'b0;
  logic inj_done = 1'b0;
  int start_cnt = 0;
  logic [3:0]  st_op = 4'd0;
  logic [31:0] st_a = 32'd0;
  logic [31:0] st_b = 32'd0;
  assign alu_done = done_r | inj_done;

  // ALU responder: done pulse alu_lat cycles after start unless hung
  always @(posedge clk) begin
    done_r <= 1'b0;
    if (alu_start) begin
      start_cnt  <= start_cnt + 1;
      st_op      <= alu_op;
      st_a       <= alu_a;
      st_b       <= alu_b;
      alu_result <= alu_fn(alu_op, alu_a, alu_b);
      if (!alu_hang) begin
        if (alu_lat <= 1) done_r <= 1'b1;
        else              pend <= alu_lat - 1;
      end
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) done_r <= 1'b1;
    end
  end

  // Result FIFO capture
  int push_cnt = 0;
  logic [31:0] push_val [0:255];
  int push_cyc [0:255];
  always @(posedge clk) begin
    if (res_push) begin
      push_val[push_cnt[7:0]] <= res_din;
      push_cyc[push_cnt[7:0]] <= cyc;
      push_cnt <= push_cnt + 1;
    end
  end

  task automatic push_inst(input logic [31:0] inst);
    fifo_mem[wr_ptr[9:0]] = inst;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_status(input logic [1:0] target, input int max_cyc, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (status == target) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_leave(input logic [1:0] from, input int max_cyc, output int at, output bit ok);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (status != from) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic launch(output int f, output bit ok);
    @(negedge clk);
    op_start = 1'b1;
    wait_status(2'b01, 4, f, ok);
    op_start = 1'b0;
  endtask

  task automatic clear_run();
    wr_ptr = rd_ptr;
    @(negedge clk);
    op_start = 1'b0;
    opdone_clear = 1'b1;
    @(negedge clk);
    opdone_clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status: got %b expected 00", status); end
    checks++; if ({inst_pop, alu_start, res_push} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {inst_pop, alu_start, res_push}); end
    checks++; if ({rf_raddr, alu_op, alu_a, alu_b, res_din} !== 104'd0) begin errors++; $display("FAIL reset_datapath: got nonzero expected 0"); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b expected 00", status); end
  endtask

  task automatic test_basic();
    int f, e, p0, s0, n0;
    bit ok;
    rf[1] = 32'd5; rf[2] = 32'd7;
    p0 = rd_ptr; s0 = start_cnt; n0 = push_cnt;
    alu_lat = 1;
    push_inst(32'h0000_0112);
    launch(f, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_fetch: got timeout expected status 01"); end
    wait_leave(2'b01, 40, e, ok);
    checks++; if (status !== 2'b10) begin errors++; $display("FAIL basic_status: got %b expected 10", status); end
    checks++; if (rd_ptr - p0 != 1) begin errors++; $display("FAIL basic_pops: got %0d expected 1", rd_ptr - p0); end
    checks++; if (start_cnt - s0 != 1) begin errors++; $display("FAIL basic_starts: got %0d expected 1", start_cnt - s0); end
    checks++; if ({st_op, st_a, st_b} !== {4'd1, 32'd5, 32'd7}) begin errors++; $display("FAIL basic_operands: got op=%0d a=%0d b=%0d expected 1 5 7", st_op, st_a, st_b); end
    checks++; if (push_cnt - n0 != 1) begin errors++; $display("FAIL basic_pushes: got %0d expected 1", push_cnt - n0); end
    checks++; if (push_val[n0[7:0]] !== 32'd12) begin errors++; $display("FAIL basic_result: got %0d expected 12", push_val[n0[7:0]]); end
    checks++; if (push_cyc[n0[7:0]] - f != 5) begin errors++; $display("FAIL basic_push_cycle: got %0d expected 5", push_cyc[n0[7:0]] - f); end
    checks++; if (e - f != 7) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 7", e - f); end
    clear_run();
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL basic_clear: got %b expected 00", status); end
  endtask

  task automatic test_empty();
    int f, e, p0, s0, n0;
    bit ok;
    p0 = rd_ptr; s0 = start_cnt; n0 = push_cnt;
    launch(f, ok);
    wait_leave(2'b01, 4, e, ok);
    checks++; if (status !== 2'b10 || e - f != 1) begin errors++; $display("FAIL empty_done: got status %b after %0d expected 10 after 1", status, e - f); end
    checks++; if ({rd_ptr - p0, start_cnt - s0, push_cnt - n0} != {32'd0, 32'd0, 32'd0}) begin errors++; $display("FAIL empty_activity: got pops %0d starts %0d pushes %0d expected 0 0 0", rd_ptr - p0, start_cnt - s0, push_cnt - n0); end
    clear_run();
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL empty_clear: got %b expected 00", status); end
  endtask

  task automatic test_invalid_nop();
    int f, e, p0, s0, n0;
    bit ok;
    p0 = rd_ptr; s0 = start_cnt; n0 = push_cnt;
    push_inst(32'h0000_0E12);
    push_inst(32'h0000_0112);
    launch(f, ok);
    wait_leave(2'b01, 20, e, ok);
    checks++; if (status !== 2'b11 || e - f != 2) begin errors++; $display("FAIL invalid_fault: got status %b after %0d expected 11 after 2", status, e - f); end
    checks++; if ({rd_ptr - p0, start_cnt - s0, push_cnt - n0} != {32'd1, 32'd0, 32'd0}) begin errors++; $display("FAIL invalid_activity: got pops %0d starts %0d pushes %0d expected 1 0 0", rd_ptr - p0, start_cnt - s0, push_cnt - n0); end
    clear_run();
    p0 = rd_ptr; n0 = push_cnt;
    push_inst(32'h0000_0012);
    push_inst(32'h0000_0112);
    launch(f, ok);
    wait_leave(2'b01, 40, e, ok);
    checks++; if (status !== 2'b10 || e - f != 9) begin errors++; $display("FAIL nop_done: got status %b after %0d expected 10 after 9", status, e - f); end
    checks++; if (rd_ptr - p0 != 2 || push_cnt - n0 != 1) begin errors++; $display("FAIL nop_counts: got pops %0d pushes %0d expected 2 1", rd_ptr - p0, push_cnt - n0); end
    checks++; if (push_val[n0[7:0]] !== 32'd12) begin errors++; $display("FAIL nop_result: got %0d expected 12", push_val[n0[7:0]]); end
    clear_run();
  endtask

  task automatic test_res_full();
    int f, e, n0;
    bit ok;
    n0 = push_cnt;
    res_full = 1'b1;
    push_inst(32'h0000_0312);
    launch(f, ok);
    wait_leave(2'b01, 40, e, ok);
    checks++; if (status !== 2'b11 || e - f != 6) begin errors++; $display("FAIL full_fault: got status %b after %0d expected 11 after 6", status, e - f); end
    checks++; if (push_cnt - n0 != 0) begin errors++; $display("FAIL full_push: got %0d expected 0", push_cnt - n0); end
    res_full = 1'b0;
    clear_run();
  endtask

  task automatic test_timeout();
    int f, e, n0;
    bit ok;
    n0 = push_cnt;
    alu_hang = 1'b1;
    push_inst(32'h0000_0112);
    launch(f, ok);
    wait_leave(2'b01, 60, e, ok);
    checks++; if (status !== 2'b11 || e - f != 4 + TIMEOUT) begin errors++; $display("FAIL timeout_fault: got status %b after %0d expected 11 after %0d", status, e - f, 4 + TIMEOUT); end
    @(negedge clk); inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (status !== 2'b11 || push_cnt != n0) begin errors++; $display("FAIL timeout_late_done: got status %b pushes %0d expected 11 0", status, push_cnt - n0); end
    alu_hang = 1'b0;
    clear_run();
    // done on the last allowed wait cycle still completes
    n0 = push_cnt;
    alu_lat = TIMEOUT;
    push_inst(32'h0000_0112);
    launch(f, ok);
    wait_leave(2'b01, 60, e, ok);
    checks++; if (status !== 2'b10 || push_cnt - n0 != 1) begin errors++; $display("FAIL timeout_edge_ok: got status %b pushes %0d expected 10 1", status, push_cnt - n0); end
    checks++; if (push_cyc[n0[7:0]] - f != 4 + TIMEOUT) begin errors++; $display("FAIL timeout_edge_cycle: got %0d expected %0d", push_cyc[n0[7:0]] - f, 4 + TIMEOUT); end
    clear_run();
    n0 = push_cnt;
    alu_lat = TIMEOUT + 1;
    push_inst(32'h0000_0112);
    launch(f, ok);
    wait_leave(2'b01, 60, e, ok);
    repeat (3) @(negedge clk);
    checks++; if (status !== 2'b11 || push_cnt != n0) begin errors++; $display("FAIL timeout_edge_late: got status %b pushes %0d expected 11 0", status, push_cnt - n0); end
    alu_lat = 1;
    clear_run();
  endtask

  task automatic test_reset_mid_wait();
    int f, p0;
    bit ok;
    alu_hang = 1'b1;
    rf[1] = 32'd5; rf[2] = 32'd7;
    push_inst(32'h0000_0112);
    push_inst(32'h0000_0112);
    launch(f, ok);
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL rstwait_status: got %b expected 00", status); end
    checks++; if ({inst_pop, alu_start, res_push} !== 3'b000 || alu_a !== 32'd0) begin errors++; $display("FAIL rstwait_outputs: got strobes %b alu_a %0d expected 000 0", {inst_pop, alu_start, res_push}, alu_a); end
    @(negedge clk);
    wr_ptr = rd_ptr;
    p0 = rd_ptr;
    alu_hang = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (status !== 2'b00 || rd_ptr != p0) begin errors++; $display("FAIL rstwait_idle: got status %b pops %0d expected 00 0", status, rd_ptr - p0); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int n, lat, f, e, p0, s0, n0, exp_pops, exp_starts, exp_cyc;
      bit ok, fault;
      logic [31:0] prog [0:5];
      logic [31:0] exp_q [$];
      logic [1:0] exp_status;
      n = int'($urandom_range(1, 6));
      lat = int'($urandom_range(1, 4));
      alu_lat = lat;
      for (int i = 0; i < 16; i++) rf[i] = $urandom;
      for (int i = 0; i < n; i++) begin
        logic [31:0] rnd;
        logic [3:0] op;
        rnd = $urandom;
        op = 4'($urandom_range(0, 12));
        if (i == n - 1 && $urandom_range(0, 3) == 0) op = 4'($urandom_range(13, 15));
        prog[i] = {rnd[31:12], op, rnd[7:0]};
      end
      exp_pops = 0; exp_starts = 0; exp_cyc = 0; fault = 1'b0;
      for (int i = 0; i < n; i++) begin
        logic [3:0] op;
        op = prog[i][11:8];
        exp_pops++;
        if (op > 4'd12) begin
          exp_cyc += 2;
          fault = 1'b1;
          break;
        end else if (op == 4'd0) begin
          exp_cyc += 2;
        end else begin
          exp_starts++;
          exp_q.push_back(alu_fn(op, rf[prog[i][7:4]], rf[prog[i][3:0]]));
          exp_cyc += lat + 5;
        end
      end
      if (!fault) exp_cyc += 1;
      exp_status = fault ? 2'b11 : 2'b10;
      p0 = rd_ptr; s0 = start_cnt; n0 = push_cnt;
      for (int i = 0; i < n; i++) push_inst(prog[i]);
      launch(f, ok);
      wait_leave(2'b01, 200, e, ok);
      checks++; if (ok !== 1'b1 || status !== exp_status) begin errors++; $display("FAIL rand%0d_status: got %b expected %b", r, status, exp_status); end
      checks++; if (e - f != exp_cyc) begin errors++; $display("FAIL rand%0d_cycles: got %0d expected %0d", r, e - f, exp_cyc); end
      checks++; if (rd_ptr - p0 != exp_pops || start_cnt - s0 != exp_starts) begin errors++; $display("FAIL rand%0d_counts: got pops %0d starts %0d expected %0d %0d", r, rd_ptr - p0, start_cnt - s0, exp_pops, exp_starts); end
      checks++; if (push_cnt - n0 != exp_q.size()) begin errors++; $display("FAIL rand%0d_pushes: got %0d expected %0d", r, push_cnt - n0, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < push_cnt - n0; i++) begin
        int idx;
        idx = n0 + i;
        checks++; if (push_val[idx[7:0]] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_result%0d: got %h expected %h", r, i, push_val[idx[7:0]], exp_q[i]); end
      end
      clear_run();
    end
    alu_lat = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_invalid_nop();
    test_res_full();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Execution controller for the ALU datapath behind the ALU bus slave. Starts on op_start, drains the instruction FIFO, and reads two operands from the register file for each instruction. It issues each operation to the ALU core, pushes the result into the result FIFO, and reports progress on the 2-bit status consumed by the slave (interrupt/status registers). A watchdog turns a hung ALU into a fault instead of a deadlock.

Parameters:
DATA_W, 32, datapath/instruction/result width
RF_AW, 4, register-file address width
TIMEOUT, 64, max WAIT cycles before fault (>=2)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
op_start  in  1  level; run request from OPERATION_START register
opdone_clear  in  1  level; releases DONE/FAULT back to IDLE
status  out  2  00 idle, 01 executing, 10 done, 11 fault
inst_empty  in  1  instruction FIFO empty
inst_dout  in  32  FIFO head (first-word-fall-through)
inst_pop  out  1  one-cycle pop strobe
rf_raddr  out  RF_AW  register-file read address (combinational read)
rf_rdata  in  DATA_W  read data, valid same cycle
alu_op  out  4  opcode to ALU core
alu_a  out  DATA_W  operand A
alu_b  out  DATA_W  operand B
alu_start  out  1  one-cycle start pulse
alu_done  in  1  ALU result valid pulse
alu_result  in  DATA_W  ALU result
res_full  in  1  result FIFO full
res_push  out  1  one-cycle push strobe
res_din  out  DATA_W  data pushed

Behaviour:
- Reset (async, reset_n=0): state IDLE, status=00, all strobes 0, rf_raddr/alu_op/alu_a/alu_b/res_din=0, watchdog=0; an in-flight instruction is discarded.
- Instruction fields: [11:8] opcode, [7:4] src A reg, [3:0] src B reg; [31:12] ignored. Opcode 0=NOP, 1..C valid, D..F invalid.
- IDLE (status 00): op_start=1 -> FETCH.
- FETCH (01): inst_empty=1 -> DONE. Else inst_pop=1 for this cycle, latch inst_dout -> READ_A.
- READ_A: decode. Invalid -> FAULT. NOP -> FETCH (no ALU, no push). Else rf_raddr=srcA, latch rf_rdata into A -> READ_B.
- READ_B: rf_raddr=srcB, latch B -> EXEC.
- EXEC: alu_start=1 for one cycle; alu_op/alu_a/alu_b driven from EXEC and held stable through WAIT; watchdog cleared -> WAIT.
- WAIT: alu_done sampled only here (ignored in EXEC). alu_done=1 -> latch alu_result -> WRITE. Else watchdog increments; reaching TIMEOUT -> FAULT.
- WRITE: res_full=0 -> res_push=1, res_din=result -> FETCH. res_full=1 -> FAULT with no push; the result is dropped.
- DONE (10) / FAULT (11): hold until opdone_clear=1 -> IDLE. With op_start and opdone_clear both high, IDLE lasts one cycle, then FETCH.
- Latency: ALU done k>=1 cycles after start gives k+5 cycles per instruction from FETCH to WRITE; NOP takes 2 cycles.
- op_start falling mid-run is ignored; the run ends only on FIFO empty or a fault.
- status is registered and changes on the clock edge that enters the state. The slave accepts instruction pushes only when status=00.
- No pops outside FETCH; at most one pop and one push per instruction.

Decomposition:
- Shared package/include: state encodings (IDLE, FETCH, READ_A, READ_B, EXEC, WAIT, WRITE, DONE, FAULT), status codes, opcode constants (OP_NOP, OP_MAX_VALID=4'hC), instruction field bit positions.
- One sub-module, alu_seq_watchdog: clear/enable counter with an expired flag at TIMEOUT.

Test Plan:
- Reset asserted mid-WAIT -> status=00, alu_start/inst_pop/res_push=0 immediately (async); IDLE after release.
- r1=5, r2=7, inst 32'h0000_0112, ALU returns 12 one cycle after start, op_start=1 -> exactly one pop, alu_op=1, alu_a=5, alu_b=7, res_push with 32'd12 6 cycles after FETCH entry, then status=10.
- FIFO empty, op_start=1 -> FETCH then DONE (status 10) within 2 cycles, no pop/start/push; opdone_clear=1 -> 00.
- Inst 32'h0000_0E12 -> status 11 after READ_A, no alu_start, no push; NOP 32'h0000_0012 followed by a valid inst -> only one result pushed.
- res_full=1 at WRITE -> status 11, res_push stays 0.
- TIMEOUT=16, alu_done held low -> FAULT exactly 16 WAIT cycles after EXEC; a late alu_done after that is ignored.
